// File: rtl/em_stage.sv
// em_stage: execute/memory stage of the 10-bit pipeline.
//
// Takes the latched FD->EM bundle, runs the ALU, and either produces a
// one-cycle registered writeback (non-memory ops) or issues a data-memory
// request and waits for dmem_ack (LOAD/STORE). While a request is outstanding
// the stage raises stall. An access that sees no ack for MEM_TIMEOUT wait
// cycles is aborted and the sticky mem_err flag is raised.
//
// Optional feature macro: EM_FWD_EN
//   When defined, the previous cycle's writeback (wb_valid/wb_addr/wb_data)
//   is forwarded onto ALU operand A if wb_addr matches gp_rdata1_address_in.
//
// Ports:
//   clk, reset (async, active-low)
//   in_valid, gp_rdata1_address_in, gp_rdata2_address_in, aluA_in, aluB_in,
//   alu_ctrl_in, gp_reg_wb_in, mem_we_in, mem_re_in, store_data_in : FD->EM bundle
//   dmem_req/we/addr/wdata (out), dmem_ack/rdata (in) : data-memory handshake
//   stall (out)                        : stage busy, upstream must hold
//   wb_valid/wb_addr/wb_data (out)     : registered writeback bundle
//   mem_err (out), err_clr (in)        : sticky timeout flag and its clear
module em_stage #(
    parameter int unsigned DW          = 10,
    parameter int unsigned RW          = 3,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [RW-1:0] gp_rdata1_address_in,
    input  logic [RW-1:0] gp_rdata2_address_in,
    input  logic [DW-1:0] aluA_in,
    input  logic [DW-1:0] aluB_in,
    input  logic [2:0]    alu_ctrl_in,
    input  logic          gp_reg_wb_in,
    input  logic          mem_we_in,
    input  logic          mem_re_in,
    input  logic [DW-1:0] store_data_in,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [DW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    input  logic          dmem_ack,
    input  logic [DW-1:0] dmem_rdata,
    output logic          stall,
    output logic          wb_valid,
    output logic [RW-1:0] wb_addr,
    output logic [DW-1:0] wb_data,
    output logic          mem_err,
    input  logic          err_clr
);

    typedef enum logic [0:0] {StIdle, StMemWait} state_e;

    state_e        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [DW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [RW-1:0] dst_q, dst_d;
    logic          wb_en_q, wb_en_d;
    logic          is_load_q, is_load_d;
    logic          wb_valid_q, wb_valid_d;
    logic [RW-1:0] wb_addr_q, wb_addr_d;
    logic [DW-1:0] wb_data_q, wb_data_d;
    logic          err_q, err_d;
    logic          timeout;

    logic [DW-1:0] op_a;
    logic [DW-1:0] alu_res;
    logic [3:0]    shamt;

    // Operand A selection.
    always_comb begin
        op_a = aluA_in;
`ifdef EM_FWD_EN
        if (wb_valid_q && (wb_addr_q == gp_rdata1_address_in)) begin
            op_a = wb_data_q;
        end
`endif
    end

`ifndef EM_FWD_EN
    logic unused_src;
    assign unused_src = ^gp_rdata1_address_in;
`endif

    // ALU: modulo 2^DW, shifts by B[3:0] with out-of-range amounts giving 0.
    always_comb begin
        shamt   = aluB_in[3:0];
        alu_res = '0;
        case (alu_ctrl_in)
            3'd0: alu_res = op_a + aluB_in;
            3'd1: alu_res = op_a - aluB_in;
            3'd2: alu_res = op_a & aluB_in;
            3'd3: alu_res = op_a | aluB_in;
            3'd4: alu_res = op_a ^ aluB_in;
            3'd5: alu_res = (32'(shamt) >= DW) ? '0 : (op_a << shamt);
            3'd6: alu_res = (32'(shamt) >= DW) ? '0 : (op_a >> shamt);
            default: alu_res = aluB_in;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        dst_d      = dst_q;
        wb_en_d    = wb_en_q;
        is_load_d  = is_load_q;
        wb_valid_d = 1'b0;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        timeout    = 1'b0;

        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    if (mem_we_in || mem_re_in) begin
                        state_d   = StMemWait;
                        req_d     = 1'b1;
                        addr_d    = alu_res;
                        we_d      = mem_we_in;
                        wdata_d   = store_data_in;
                        // Write wins when both enables are set.
                        is_load_d = ~mem_we_in;
                        wb_en_d   = gp_reg_wb_in;
                        dst_d     = gp_rdata2_address_in;
                        cnt_d     = '0;
                    end else if (gp_reg_wb_in) begin
                        wb_valid_d = 1'b1;
                        wb_addr_d  = gp_rdata2_address_in;
                        wb_data_d  = alu_res;
                    end
                end
            end
            StMemWait: begin
                if (dmem_ack) begin
                    state_d = StIdle;
                    req_d   = 1'b0;
                    if (is_load_q && wb_en_q) begin
                        wb_valid_d = 1'b1;
                        wb_addr_d  = dst_q;
                        wb_data_d  = dmem_rdata;
                    end
                end else if (cnt_q == 8'(MEM_TIMEOUT - 1)) begin
                    state_d = StIdle;
                    req_d   = 1'b0;
                    timeout = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Set beats clear.
        if (timeout) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            dst_q      <= '0;
            wb_en_q    <= 1'b0;
            is_load_q  <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            dst_q      <= dst_d;
            wb_en_q    <= wb_en_d;
            is_load_q  <= is_load_d;
            wb_valid_q <= wb_valid_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            err_q      <= err_d;
        end
    end

    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign stall      = (state_q == StMemWait);
    assign wb_valid   = wb_valid_q;
    assign wb_addr    = wb_addr_q;
    assign wb_data    = wb_data_q;
    assign mem_err    = err_q;

endmodule

// File: tb/tb_em_stage.sv
// tb_em_stage: directed literal checks plus randomized traffic for em_stage,
// with every output compared each cycle against a behavioural model.
module tb_em_stage;

    localparam int DW  = 10;
    localparam int RW  = 3;
    localparam int TMO = 15;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic [RW-1:0] src = '0;
    logic [RW-1:0] dst = '0;
    logic [DW-1:0] a_in = '0;
    logic [DW-1:0] b_in = '0;
    logic [2:0]    ctrl = '0;
    logic          gp_wb = 1'b0;
    logic          m_we_in = 1'b0;
    logic          m_re_in = 1'b0;
    logic [DW-1:0] sdata = '0;
    logic          dmem_ack = 1'b0;
    logic [DW-1:0] dmem_rdata = '0;
    logic          err_clr = 1'b0;

    logic          dmem_req, dmem_we, stall, wb_valid, mem_err;
    logic [DW-1:0] dmem_addr, dmem_wdata, wb_data;
    logic [RW-1:0] wb_addr;

    always #5 clk = ~clk;

    em_stage #(.DW(DW), .RW(RW), .MEM_TIMEOUT(TMO)) dut (
        .clk                  (clk),
        .reset                (reset),
        .in_valid             (in_valid),
        .gp_rdata1_address_in (src),
        .gp_rdata2_address_in (dst),
        .aluA_in              (a_in),
        .aluB_in              (b_in),
        .alu_ctrl_in          (ctrl),
        .gp_reg_wb_in         (gp_wb),
        .mem_we_in            (m_we_in),
        .mem_re_in            (m_re_in),
        .store_data_in        (sdata),
        .dmem_req             (dmem_req),
        .dmem_we              (dmem_we),
        .dmem_addr            (dmem_addr),
        .dmem_wdata           (dmem_wdata),
        .dmem_ack             (dmem_ack),
        .dmem_rdata           (dmem_rdata),
        .stall                (stall),
        .wb_valid             (wb_valid),
        .wb_addr              (wb_addr),
        .wb_data              (wb_data),
        .mem_err              (mem_err),
        .err_clr              (err_clr)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ALU rules in plain integer arithmetic.
    function automatic logic [DW-1:0] alu_ref(input int a, input int b, input int op);
        int r;
        int sh;
        int mask;
        mask = (1 << DW) - 1;
        sh   = b % 16;
        case (op)
            0: r = a + b;
            1: r = a - b;
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = (sh >= DW) ? 0 : (a << sh);
            6: r = (sh >= DW) ? 0 : (a >> sh);
            default: r = b;
        endcase
        return DW'(r & mask);
    endfunction

    // Behavioural model state.
    bit            m_busy;
    int            m_waited;
    logic          m_req, m_we, m_wbv, m_err, m_load, m_wben, new_wbv, tmo;
    logic [DW-1:0] m_addr, m_wdata, m_wbd, r;
    logic [RW-1:0] m_wba, m_dst;
    int            op_a;

    task automatic model_reset();
        m_busy = 0; m_waited = 0; m_req = 0; m_we = 0; m_wbv = 0; m_err = 0;
        m_load = 0; m_wben = 0; m_addr = '0; m_wdata = '0; m_wbd = '0;
        m_wba = '0; m_dst = '0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                model_reset();
            end else begin
                tmo     = 0;
                new_wbv = 0;
                if (!m_busy) begin
                    if (in_valid) begin
                        op_a = int'(a_in);
`ifdef EM_FWD_EN
                        if (m_wbv && m_wba == src) op_a = int'(m_wbd);
`endif
                        r = alu_ref(op_a, int'(b_in), int'(ctrl));
                        if (m_we_in || m_re_in) begin
                            m_busy = 1; m_req = 1; m_addr = r; m_we = m_we_in;
                            m_wdata = sdata; m_load = !m_we_in; m_wben = gp_wb;
                            m_dst = dst; m_waited = 0;
                        end else if (gp_wb) begin
                            new_wbv = 1; m_wba = dst; m_wbd = r;
                        end
                    end
                end else begin
                    if (dmem_ack) begin
                        m_busy = 0; m_req = 0;
                        if (m_load && m_wben) begin
                            new_wbv = 1; m_wba = m_dst; m_wbd = dmem_rdata;
                        end
                    end else if (m_waited == TMO - 1) begin
                        m_busy = 0; m_req = 0; tmo = 1;
                    end else begin
                        m_waited++;
                    end
                end
                m_err = tmo ? 1'b1 : (err_clr ? 1'b0 : m_err);
                m_wbv = new_wbv;
            end
            #1;
            check("cyc_req",   32'(dmem_req),   32'(m_req));
            check("cyc_we",    32'(dmem_we),    32'(m_we));
            check("cyc_addr",  32'(dmem_addr),  32'(m_addr));
            check("cyc_wdata", 32'(dmem_wdata), 32'(m_wdata));
            check("cyc_stall", 32'(stall),      32'(m_busy));
            check("cyc_wbv",   32'(wb_valid),   32'(m_wbv));
            check("cyc_wba",   32'(wb_addr),    32'(m_wba));
            check("cyc_wbd",   32'(wb_data),    32'(m_wbd));
            check("cyc_err",   32'(mem_err),    32'(m_err));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [2:0] c,
                         input logic [RW-1:0] s, input logic [RW-1:0] d, input logic w,
                         input logic we, input logic re, input logic [DW-1:0] sd);
        in_valid = 1'b1; a_in = a; b_in = b; ctrl = c; src = s; dst = d; gp_wb = w;
        m_we_in = we; m_re_in = re; sdata = sd;
    endtask

    int cnt;
    int target;
    int wcnt;
    bit was_req;
    int sel;
    logic [DW-1:0] fwd_exp;

    initial begin
        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_req",   32'(dmem_req),  32'(0));
        check("rst_stall", 32'(stall),     32'(0));
        check("rst_wbv",   32'(wb_valid),  32'(0));
        check("rst_err",   32'(mem_err),   32'(0));
        check("rst_addr",  32'(dmem_addr), 32'(0));
        check("rst_wbd",   32'(wb_data),   32'(0));
        reset = 1'b1;

        // ADD wrap-around.
        issue(10'h3FF, 10'd1, 3'd0, 3'd0, 3'd5, 1'b1, 1'b0, 1'b0, '0);
        tick();
        in_valid = 1'b0;
        check("add_wbv",   32'(wb_valid), 32'(1));
        check("add_wba",   32'(wb_addr),  32'(5));
        check("add_wbd",   32'(wb_data),  32'(0));
        check("add_stall", 32'(stall),    32'(0));

        // LOAD, ack in the third wait cycle.
        issue(10'h100, 10'd4, 3'd0, 3'd0, 3'd2, 1'b1, 1'b0, 1'b1, '0);
        tick();
        in_valid = 1'b0;
        check("ld_req",  32'(dmem_req),  32'(1));
        check("ld_addr", 32'(dmem_addr), 32'h104);
        check("ld_we",   32'(dmem_we),   32'(0));
        for (int i = 0; i < 3; i++) begin
            check("ld_stall", 32'(stall), 32'(1));
            if (i == 2) begin
                dmem_ack = 1'b1; dmem_rdata = 10'h2AA;
            end
            tick();
        end
        dmem_ack = 1'b0;
        check("ld_wbv",   32'(wb_valid), 32'(1));
        check("ld_wba",   32'(wb_addr),  32'(2));
        check("ld_wbd",   32'(wb_data),  32'h2AA);
        check("ld_done",  32'(stall),    32'(0));

        // STORE with both enables set.
        issue(10'h020, 10'd0, 3'd0, 3'd0, 3'd6, 1'b1, 1'b1, 1'b1, 10'h155);
        tick();
        in_valid = 1'b0;
        check("st_we",    32'(dmem_we),    32'(1));
        check("st_wdata", 32'(dmem_wdata), 32'h155);
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        check("st_wbv", 32'(wb_valid), 32'(0));
        check("st_req", 32'(dmem_req), 32'(0));

        // LOAD that never gets an ack.
        issue(10'h050, 10'd0, 3'd0, 3'd0, 3'd1, 1'b1, 1'b0, 1'b1, '0);
        tick();
        in_valid = 1'b0;
        cnt = 0;
        while (dmem_req && cnt < 40) begin
            cnt++;
            tick();
        end
        check("tmo_req_cycles", 32'(cnt), 32'(15));
        check("tmo_err",        32'(mem_err),  32'(1));
        check("tmo_wbv",        32'(wb_valid), 32'(0));
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("clr_err", 32'(mem_err), 32'(0));

        // Dependent back-to-back ADDs.
        issue(10'h010, 10'd0, 3'd0, 3'd0, 3'd3, 1'b1, 1'b0, 1'b0, '0);
        tick();
        issue(10'h000, 10'd1, 3'd0, 3'd3, 3'd4, 1'b1, 1'b0, 1'b0, '0);
        tick();
        in_valid = 1'b0;
`ifdef EM_FWD_EN
        fwd_exp = 10'h011;
`else
        fwd_exp = 10'h001;
`endif
        check("fwd_wbd", 32'(wb_data), 32'(fwd_exp));

        // Reset asserted mid-access.
        issue(10'h0A0, 10'd0, 3'd0, 3'd0, 3'd1, 1'b1, 1'b0, 1'b1, '0);
        tick();
        in_valid = 1'b0;
        check("mid_req_pre", 32'(dmem_req), 32'(1));
        #2;
        reset = 1'b0;
        #1;
        check("mid_req",   32'(dmem_req), 32'(0));
        check("mid_stall", 32'(stall),    32'(0));
        check("mid_wbv",   32'(wb_valid), 32'(0));
        check("mid_err",   32'(mem_err),  32'(0));
        @(negedge clk);
        reset = 1'b1;

        // Randomized traffic.
        was_req = 0; target = 0; wcnt = 0;
        for (int i = 0; i < 3000; i++) begin
            if (dmem_req) begin
                if (!was_req) begin
                    target = $urandom_range(0, 17);
                    wcnt   = 0;
                end else begin
                    wcnt++;
                end
                dmem_ack = (wcnt == target);
            end else begin
                dmem_ack = ($urandom % 8 == 0);
            end
            was_req    = dmem_req;
            dmem_rdata = DW'($urandom);
            in_valid   = ($urandom % 4 != 0);
            a_in       = DW'($urandom);
            b_in       = DW'($urandom);
            ctrl       = 3'($urandom);
            src        = RW'($urandom);
            dst        = RW'($urandom);
            gp_wb      = ($urandom % 4 != 0);
            sdata      = DW'($urandom);
            sel        = $urandom % 8;
            m_re_in    = (sel == 0) || (sel == 2);
            m_we_in    = (sel == 1) || (sel == 2);
            err_clr    = ($urandom % 16 == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
